gtech_dispatch4: RTL and testbench

//  Splits one valid/ready input stream across four output channels in round-robin order.

---
 rtl/gtech_dispatch4.sv | 84 ++++++++
 tb/tb_gtech_dispatch4.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gtech_dispatch4.sv
// Round-robin dispatcher: one valid/ready input stream fanned out to four
// single-entry output channels, skipping channels that are full or disabled.
module gtech_dispatch4 #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [3:0]       ch_en,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [4*W-1:0]   out_data,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  logic [3:0]       valid_vec;
  logic [3:0]       free;
  logic [7:0]       free2;
  logic [3:0]       rot;
  logic [1:0]       offset;
  logic [1:0]       sel;
  logic             accept;
  logic [1:0]       ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // free ignores out_ready, so a channel is never refilled on its drain edge.
  assign free     = ch_en & ~valid_vec;
  assign in_ready = |free;
  assign accept   = in_valid & in_ready;

  // Rotate free so bit 0 is the channel at ptr, then take the first set bit.
  assign free2 = {free, free};
  assign rot   = free2[ptr_reg +: 4];

  always_comb begin
    offset = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) offset = 2'(i);
    end
  end

  assign sel = ptr_reg + offset;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic         full_reg;
      logic [W-1:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_reg <= 1'b0;
          word_reg <= '0;
        end else if (accept && (sel == 2'(gi))) begin
          full_reg <= 1'b1;
          word_reg <= in_data;
        end else if (full_reg && out_ready[gi]) begin
          full_reg <= 1'b0;
        end
      end

      assign valid_vec[gi]          = full_reg;
      assign out_data[gi*W +: W]    = word_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= 2'd0;
      count_reg <= '0;
    end else if (accept) begin
      ptr_reg   <= sel + 2'd1;
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign out_valid = valid_vec;
  assign busy      = |valid_vec;
  assign count     = count_reg;

endmodule

// File: tb/tb_gtech_dispatch4.sv
// Randomized scoreboard bench for gtech_dispatch4: a channel-level model
// predicts routing, flow control and counters; a monitor checks drained words.
module tb_gtech_dispatch4;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [3:0]       ch_en;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*W-1:0]   out_data;
  logic             busy;
  logic [CNT_W-1:0] count;

  gtech_dispatch4 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mfull[4];
  int         mptr;
  logic [3:0] mcount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int find_ch(input int k);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].ch == k) return i;
    return -1;
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mfull[k];
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) mfull[k] = 1'b0;
    mptr   = 0;
    mcount = '0;
  endtask

  // One cycle: drive at posedge+1, check comb ready, then check state after the edge.
  task automatic step(input bit v, input logic [7:0] d, input logic [3:0] en, input logic [3:0] ordy);
    int sel;
    bit any;
    int idx;
    in_valid  = v;
    in_data   = d;
    ch_en     = en;
    out_ready = ordy;
    #1;
    any = 1'b0;
    sel = -1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (mptr + i) % 4;
      if (!any && en[k] && !mfull[k]) begin
        any = 1'b1;
        sel = k;
      end
    end
    check("in_ready", 32'(in_ready), 32'(any));
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (mfull[k] && ordy[k]) mfull[k] = 1'b0;
    if (v && any) begin
      mfull[sel] = 1'b1;
      mptr       = (sel + 1) % 4;
      mcount     = mcount + 4'd1;
      exp_q.push_back('{sel, d});
      $display("accept ch%0d data %02h count %0d", sel, d, mcount);
    end
    check("out_valid", 32'(out_valid), 32'(model_valid()));
    check("busy", 32'(busy), 32'(|model_valid()));
    check("count", 32'(count), 32'(mcount));
    for (int k = 0; k < 4; k++) begin
      if (mfull[k]) begin
        idx = find_ch(k);
        if (idx >= 0) check("hold_data", 32'(out_data[k*W +: W]), 32'(exp_q[idx].d));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every drain handshake must deliver the oldest expected word of that channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          int idx;
          idx = find_ch(k);
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected: ch%0d got %02h required none", k, out_data[k*W +: W]);
          end else begin
            check("drain_data", 32'(out_data[k*W +: W]), 32'(exp_q[idx].d));
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] en;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_en     = 4'hF;
    out_ready = 4'h0;
    rst       = 1'b1;
    #2;
    model_reset();
    check("init_out_valid", 32'(out_valid), 32'h0);
    check("init_busy", 32'(busy), 32'h0);
    check("init_count", 32'(count), 32'h0);
    check("init_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Round-robin fill, then fifth word refused while all full.
    step(1, 8'h11, 4'hF, 4'h0);
    step(1, 8'h22, 4'hF, 4'h0);
    step(1, 8'h33, 4'hF, 4'h0);
    step(1, 8'h44, 4'hF, 4'h0);
    check("fill_out_data", 32'(out_data), 32'h44332211);
    step(1, 8'h99, 4'hF, 4'h0);
    check("fill_count", 32'(count), 32'd4);
    step(0, 8'h00, 4'hF, 4'hF);

    // Skip busy channel: ch1 full, ptr=1, next word must land in ch2.
    step(1, 8'hA1, 4'b0010, 4'h0);
    step(1, 8'hA0, 4'b0001, 4'h0);
    step(0, 8'h00, 4'hF, 4'b0001);
    step(1, 8'h55, 4'hF, 4'h0);
    check("skip_ch2", 32'(out_data[2*W +: W]), 32'h55);
    check("skip_valid", 32'(out_valid), 32'b0110);
    step(1, 8'h66, 4'hF, 4'h0);
    check("skip_ptr3", 32'(out_data[3*W +: W]), 32'h66);
    step(0, 8'h00, 4'hF, 4'hF);

    // Masked stream over ch0/ch2.
    for (int i = 0; i < 6; i++) step(1, 8'(8'hB0 + i), 4'b0101, 4'hF);
    step(0, 8'h00, 4'hF, 4'hF);

    // Drain/refill on the only enabled channel.
    step(1, 8'hC1, 4'b0001, 4'h0);
    step(1, 8'hC2, 4'b0001, 4'b0001);
    step(1, 8'hC2, 4'b0001, 4'b0001);
    step(0, 8'h00, 4'hF, 4'hF);

    // Reset mid-stream with out_valid=1011.
    step(1, 8'hD0, 4'b1011, 4'h0);
    step(1, 8'hD1, 4'b1011, 4'h0);
    step(1, 8'hD3, 4'b1011, 4'h0);
    check("pre_rst_valid", 32'(out_valid), 32'b1011);
    do_reset();
    step(1, 8'hE0, 4'hF, 4'h0);
    check("post_rst_ch0", 32'(out_valid), 32'b0001);
    step(0, 8'h00, 4'hF, 4'hF);

    // Counter wrap after 16 accepts from reset.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i * 7), 4'hF, 4'hF);
    check("count_wrap", 32'(count), 32'h0);
    step(0, 8'h00, 4'hF, 4'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      step(1'($urandom), 8'($urandom), en, 4'($urandom));
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 4'hF, 4'hF);
    check("end_empty", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
